// File: rtl/pll_freq_ctrl_pkg.sv
// Shared types and helpers for the PLL frequency-control loop.
// Holds the loop FSM state encoding and the pulse-length helper.
`timescale 1ns/1ps
package pll_freq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        EVAL,
        PULSE,
        SETTLE
    } state_e;

    // Width of the error argument accepted by abs_sat (CNT_W up to 32).
    localparam int unsigned ABS_W = 33;

    // |err| >> shift, clamped to the range [1, max_len].
    function automatic logic [31:0] abs_sat(
        input logic signed [ABS_W-1:0] err,
        input int unsigned             shift,
        input logic [31:0]             max_len
    );
        logic [ABS_W-1:0] mag;
        logic [ABS_W-1:0] shd;
        mag = err[ABS_W-1] ? ABS_W'(-err) : ABS_W'(err);
        shd = mag >> shift;
        if (shd == '0) begin
            shd = ABS_W'(1);
        end
        if (shd > {1'b0, max_len}) begin
            shd = {1'b0, max_len};
        end
        return shd[31:0];
    endfunction

endpackage

// File: rtl/pll_freq_ctrl_sync_edge_det.sv
// Two-flop synchronizer with a rising-edge detector.
// Gives a one-cycle strobe in the clk_i domain per async rising edge.
`timescale 1ns/1ps
module sync_edge_det (
    input  logic clk_i,
    input  logic arst_i,
    input  logic async_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the async input and keep one cycle of history.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/pll_freq_ctrl.sv
// Frequency-control loop stage driving the behavioural VCO.
// Counts feedback edges per window and emits proportional incr/decr pulses.
`timescale 1ns/1ps
module pll_freq_ctrl
    import pll_freq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned WIN_W        = 16,
    parameter int unsigned TOL          = 2,
    parameter int unsigned LOCK_WINDOWS = 4,
    parameter int unsigned GAIN_SHIFT   = 0,
    parameter int unsigned MAX_PULSE    = 255,
    parameter int unsigned SETTLE_CYC   = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    en_i,
    input  logic                    fb_clk_i,
    input  logic [CNT_W-1:0]        target_i,
    input  logic [WIN_W-1:0]        window_i,
    output logic                    freq_incr_o,
    output logic                    freq_decr_o,
    output logic                    stable_cfg_o,
    output logic                    meas_valid_o,
    output logic signed [CNT_W:0]   err_o
);

    localparam int unsigned LOCK_W =
        (LOCK_WINDOWS > 0) ? $clog2(LOCK_WINDOWS + 1) : 1;
    localparam int unsigned PLEN_W =
        (MAX_PULSE > 0) ? $clog2(MAX_PULSE + 1) : 1;
    localparam int unsigned SET_W =
        (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

    state_e                 state_q;
    logic [CNT_W-1:0]       tgt_q;
    logic [WIN_W-1:0]       win_q;
    logic [WIN_W-1:0]       win_cnt_q;
    logic [CNT_W-1:0]       fb_cnt_q;
    logic [LOCK_W-1:0]      lock_cnt_q;
    logic [PLEN_W-1:0]      pulse_cnt_q;
    logic [SET_W-1:0]       settle_cnt_q;
    logic                   stable_q;
    logic                   incr_q;
    logic                   decr_q;
    logic                   valid_q;
    logic signed [CNT_W:0]  err_q;

    logic                   fb_edge;
    logic [WIN_W-1:0]       win_sel;
    logic                   win_last;
    logic                   pulse_last;
    logic                   settle_last;
    logic signed [CNT_W:0]  err_d;
    logic [CNT_W:0]         mag_d;
    logic                   in_tol_d;
    logic [31:0]            plen_full;
    logic [PLEN_W-1:0]      plen_d;

    sync_edge_det u_fb_sync (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .async_i (fb_clk_i),
        .edge_o  (fb_edge)
    );

    assign win_sel     = (window_i == '0) ? WIN_W'(1) : window_i;
    assign win_last    = (win_cnt_q == (win_q - WIN_W'(1)));
    assign pulse_last  = (pulse_cnt_q <= PLEN_W'(1));
    assign settle_last = (settle_cnt_q <= SET_W'(1));

    assign err_d    = $signed({1'b0, tgt_q}) - $signed({1'b0, fb_cnt_q});
    assign mag_d    = err_d[CNT_W] ? $unsigned(-err_d) : $unsigned(err_d);
    assign in_tol_d = (mag_d <= (CNT_W + 1)'(TOL));

    assign plen_full = abs_sat(ABS_W'(err_d), GAIN_SHIFT, 32'(MAX_PULSE));
    assign plen_d    = PLEN_W'(plen_full);

    // Loop FSM: measure, evaluate, pulse, settle, with registered outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= IDLE;
            tgt_q        <= '0;
            win_q        <= '0;
            win_cnt_q    <= '0;
            fb_cnt_q     <= '0;
            lock_cnt_q   <= '0;
            pulse_cnt_q  <= '0;
            settle_cnt_q <= '0;
            stable_q     <= 1'b0;
            incr_q       <= 1'b0;
            decr_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= '0;
        end else begin
            valid_q <= 1'b0;
            if (!en_i) begin
                state_q    <= IDLE;
                lock_cnt_q <= '0;
                stable_q   <= 1'b0;
                incr_q     <= 1'b0;
                decr_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q   <= MEASURE;
                        tgt_q     <= target_i;
                        win_q     <= win_sel;
                        win_cnt_q <= '0;
                        fb_cnt_q  <= '0;
                    end
                    MEASURE: begin
                        if (fb_edge && !(&fb_cnt_q)) begin
                            fb_cnt_q <= fb_cnt_q + CNT_W'(1);
                        end
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                        if (win_last) begin
                            state_q <= EVAL;
                        end
                    end
                    EVAL: begin
                        err_q   <= err_d;
                        valid_q <= 1'b1;
                        if (in_tol_d) begin
                            if (lock_cnt_q < LOCK_W'(LOCK_WINDOWS)) begin
                                lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                            end
                            if (lock_cnt_q >= LOCK_W'(LOCK_WINDOWS - 1)) begin
                                stable_q <= 1'b1;
                            end
                            state_q   <= MEASURE;
                            tgt_q     <= target_i;
                            win_q     <= win_sel;
                            win_cnt_q <= '0;
                            fb_cnt_q  <= '0;
                        end else begin
                            lock_cnt_q  <= '0;
                            stable_q    <= 1'b0;
                            incr_q      <= ~err_d[CNT_W];
                            decr_q      <= err_d[CNT_W];
                            pulse_cnt_q <= plen_d;
                            state_q     <= PULSE;
                        end
                    end
                    PULSE: begin
                        if (pulse_last) begin
                            incr_q       <= 1'b0;
                            decr_q       <= 1'b0;
                            settle_cnt_q <= SET_W'(SETTLE_CYC);
                            state_q      <= SETTLE;
                        end else begin
                            pulse_cnt_q <= pulse_cnt_q - PLEN_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (settle_last) begin
                            state_q   <= MEASURE;
                            tgt_q     <= target_i;
                            win_q     <= win_sel;
                            win_cnt_q <= '0;
                            fb_cnt_q  <= '0;
                        end else begin
                            settle_cnt_q <= settle_cnt_q - SET_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Dropping en_i silences the VCO controls in the same cycle.
    assign freq_incr_o  = incr_q & en_i;
    assign freq_decr_o  = decr_q & en_i;
    assign stable_cfg_o = stable_q;
    assign meas_valid_o = valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_pll_freq_ctrl.sv
// Directed self-checking bench for pll_freq_ctrl.
// Expected values are hand-computed from window, target and fb period.
`timescale 1ns/1ps
module tb_pll_freq_ctrl;

    logic               clk    = 1'b0;
    logic               arst   = 1'b1;
    logic               en     = 1'b0;
    logic               fb     = 1'b0;
    logic [15:0]        target = '0;
    logic [15:0]        window = '0;
    logic               incr;
    logic               decr;
    logic               stable;
    logic               valid;
    logic signed [16:0] err;

    logic               en2     = 1'b0;
    logic               fb2     = 1'b0;
    logic [15:0]        target2 = '0;
    logic [15:0]        window2 = '0;
    logic               incr2;
    logic               decr2;
    logic               stable2;
    logic               valid2;
    logic signed [16:0] err2;

    real fb_half = 0.0;
    int  total   = 0;
    int  bad     = 0;
    int  inc_cyc = 0;
    int  dec_cyc = 0;
    int  both_cyc = 0;

    pll_freq_ctrl u_dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .en_i         (en),
        .fb_clk_i     (fb),
        .target_i     (target),
        .window_i     (window),
        .freq_incr_o  (incr),
        .freq_decr_o  (decr),
        .stable_cfg_o (stable),
        .meas_valid_o (valid),
        .err_o        (err)
    );

    pll_freq_ctrl #(.GAIN_SHIFT(2)) u_dut2 (
        .clk_i        (clk),
        .arst_i       (arst),
        .en_i         (en2),
        .fb_clk_i     (fb2),
        .target_i     (target2),
        .window_i     (window2),
        .freq_incr_o  (incr2),
        .freq_decr_o  (decr2),
        .stable_cfg_o (stable2),
        .meas_valid_o (valid2),
        .err_o        (err2)
    );

    always #5 clk = ~clk;

    always begin
        if (fb_half == 0.0) begin
            fb = 1'b0;
            #5;
        end else begin
            #(fb_half) fb = ~fb;
        end
    end

    always @(negedge clk) begin
        if (incr) inc_cyc++;
        if (decr) dec_cyc++;
        if (incr && decr) both_cyc++;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!valid && cyc < 5000);
        if (!valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic meas_pulse(output int ni, output int nd);
        int bi;
        int bd;
        int n;
        bi = inc_cyc;
        bd = dec_cyc;
        n  = 0;
        while ((incr || decr) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        ni = inc_cyc - bi;
        nd = dec_cyc - bd;
    endtask

    task automatic run(input logic [15:0] t, input logic [15:0] w,
                       input real fh);
        en = 1'b0;
        @(posedge clk);
        #1;
        fb_half = fh;
        target  = t;
        window  = w;
        repeat (20) @(posedge clk);
        @(negedge clk);
        en = 1'b1;
    endtask

    initial begin
        int c;
        int e;
        int ni;
        int nd;
        int ib;
        int db;
        int nv;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_incr", incr, 0);
        chk("rst_decr", decr, 0);
        chk("rst_stable", stable, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        arst = 1'b0;

        // exact frequency: 100 edges per 1000-cycle window
        ib = inc_cyc;
        db = dec_cyc;
        run(16'd100, 16'd1000, 50.0);
        for (int k = 1; k <= 4; k++) begin
            wait_valid("exact", c);
            if (k == 1) chk("exact_latency", c, 1002);
            chk("exact_err_range", (err >= -1 && err <= 1), 1);
            chk("exact_stable", stable, (k == 4));
        end
        chk("exact_no_ctrl", (inc_cyc - ib) + (dec_cyc - db), 0);

        // slow feedback: ~90 edges, err ~ +10
        run(16'd100, 16'd1000, 55.5);
        wait_valid("slow", c);
        e = int'(err);
        chk("slow_err_range", (e >= 9 && e <= 11), 1);
        chk("slow_stable", stable, 0);
        meas_pulse(ni, nd);
        chk("slow_incr_len", ni, e);
        chk("slow_decr_len", nd, 0);
        wait_valid("slow2", c);
        chk("slow_settle_gap", c, 1017);

        // fast feedback: ~120 edges, err ~ -20
        run(16'd100, 16'd1000, 41.5);
        wait_valid("fast", c);
        e = int'(err);
        chk("fast_err_range", (e >= -21 && e <= -19), 1);
        meas_pulse(ni, nd);
        chk("fast_decr_len", nd, -e);
        chk("fast_incr_len", ni, 0);

        // saturation: no edges, target 1000
        run(16'd1000, 16'd1000, 0.0);
        wait_valid("sat", c);
        chk("sat_err", err, 1000);
        meas_pulse(ni, nd);
        chk("sat_incr_len", ni, 255);

        // window 0 behaves as 1
        run(16'd5, 16'd0, 0.0);
        wait_valid("win0", c);
        chk("win0_latency", c, 3);
        chk("win0_err", err, 5);

        // tolerance boundary and lock loss
        run(16'd2, 16'd50, 0.0);
        for (int k = 1; k <= 4; k++) begin
            wait_valid("tol", c);
            chk("tol_err", err, 2);
            chk("tol_stable", stable, (k == 4));
        end
        target = 16'd3;
        wait_valid("tol5", c);
        chk("tol5_err", err, 2);
        chk("tol5_stable", stable, 1);
        wait_valid("tol6", c);
        chk("loss_err", err, 3);
        chk("loss_stable", stable, 0);
        meas_pulse(ni, nd);
        chk("loss_incr_len", ni, 3);

        // enable abort mid-PULSE and mid-MEASURE
        run(16'd1000, 16'd100, 0.0);
        wait_valid("abortp", c);
        repeat (10) @(posedge clk);
        #2;
        en = 1'b0;
        #1;
        chk("abortp_incr_now", incr, 0);
        @(posedge clk);
        #1;
        chk("abortp_err_hold", err, 1000);

        run(16'd2, 16'd50, 0.0);
        for (int k = 1; k <= 4; k++) wait_valid("abortm", c);
        chk("abortm_locked", stable, 1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("abortm_stable", stable, 0);
        nv = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        chk("abortm_no_valid", nv, 0);

        // async reset mid-PULSE
        run(16'd1000, 16'd100, 0.0);
        wait_valid("rstp", c);
        repeat (5) @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        chk("rstp_incr", incr, 0);
        chk("rstp_err", err, 0);
        @(negedge clk);
        arst = 1'b0;
        wait_valid("rstp2", c);
        chk("rstp_restart_lat", c, 102);
        chk("rstp_err2", err, 1000);

        // GAIN_SHIFT=2 with err=3 gives the minimum 1-cycle pulse
        en = 1'b0;
        target2 = 16'd3;
        window2 = 16'd10;
        @(negedge clk);
        en2 = 1'b1;
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (!valid2 && c < 200);
        chk("g2_latency", c, 12);
        chk("g2_err", err2, 3);
        chk("g2_stable", stable2, 0);
        chk("g2_decr", decr2, 0);
        nv = 0;
        while (incr2 && nv < 50) begin
            nv++;
            @(posedge clk);
            #1;
        end
        chk("g2_pulse_len", nv, 1);

        chk("never_both", both_cyc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
